omega_unshuffle_network_ff: RTL and testbench
=============================================

OMEGA_UNSHUFFLE_NETWORK_FF -- requirements
Module: omega_unshuffle_network_ff

Interface
REQ-001 Parameter WIDTH, default 8: payload bits per lane.
REQ-002 Parameter IN_PORTS, default 8: lane count; power of two, at least 2.
REQ-003 Parameter OUT_PORTS, default IN_PORTS: output lane count; SHALL equal IN_PORTS.
REQ-004 Parameter ADDR_WIDTH_PORTS, default log2(OUT_PORTS-1): stage count and control width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-007 push  input  [0:IN_PORTS-1]  per-lane input valid.
REQ-008 d_in  input  [IN_PORTS*WIDTH-1:0]  lane i payload at bits [(i+1)*WIDTH-1 -: WIDTH].
REQ-009 control  input  [ADDR_WIDTH_PORTS-1:0]  routing word, sampled with push/d_in in the same cycle.
REQ-010 valid  output  [0:OUT_PORTS-1]  per-lane output valid.
REQ-011 d_out  output  [OUT_PORTS*WIDTH-1:0]  lane j payload at bits [(j+1)*WIDTH-1 -: WIDTH].

Function
REQ-012 The block SHALL be the return-path counterpart of the forward registered omega network: an inverse-shuffle (unshuffle) network of ADDR_WIDTH_PORTS registered stages.
REQ-013 Stage g, switch k (0 <= k < IN_PORTS/2), SHALL take lanes 2k and 2k+1 and drive lanes k (top) and k+IN_PORTS/2 (bottom) of stage g+1.
REQ-014 Switch bit 0: top <- lane 2k, bottom <- lane 2k+1; bit 1: crossed; valid bit travels with its payload.
REQ-015 Stage g SHALL use control bit g (LSB at first stage) of the control word that entered with that data.
REQ-016 The control word SHALL be pipelined alongside data (per-stage registered copy) so a new control word may be applied every cycle without disturbing words in flight.
REQ-017 Each stage SHALL register its outputs; latency from push to valid SHALL be exactly ADDR_WIDTH_PORTS cycles; throughput one word set per cycle.
REQ-018 Net mapping: data pushed on lane i with control c SHALL appear on output lane i XOR c.
REQ-019 Permutation is bijective; no collisions, no backpressure, no dropping.
REQ-020 Lanes with push=0 SHALL produce valid=0 at the corresponding output lane; d_out of such lanes is don't-care except after reset.
REQ-021 Data registers SHALL load every cycle regardless of valid.

Reset
REQ-022 While rst=0 at a rising edge, all valid registers at every stage SHALL clear to 0, all data and control pipeline registers SHALL clear to 0.
REQ-023 Reset asserted mid-flight SHALL discard all in-flight words; valid=0 from the cycle after the reset edge until new pushes propagate.
REQ-024 Inputs presented during the reset cycle SHALL be discarded.
REQ-025 First push accepted on the first edge with rst=1; its output appears ADDR_WIDTH_PORTS cycles later.

Structure
REQ-026 The log2 constant function SHALL come from the shared log2.vh include; no other shared constants.
REQ-027 One sub-module, unshuffle_switch_ff: 2x2 registered switch with WIDTH+1-bit lanes (valid in bit 0), control-bit input, synchronous active-low reset clearing valid bits.
REQ-028 Per-stage control pipeline SHALL reside in the top module.

Verification
REQ-029 Defaults, rst released, push=8'hFF, d_in lane i=8'h10+i, control=3'b101 for one cycle -> three cycles later valid=8'hFF, d_out lane j=8'h10+(j^5), then valid=0.
REQ-030 control=0, push lane 3 only, payload 8'hA5 -> after 3 cycles only valid[3]=1, d_out lane 3=8'hA5.
REQ-031 Back-to-back cycles: control 3'b001, 3'b110, 3'b111, all lanes pushed, payload 8'h20+i, 8'h40+i, 8'h60+i -> outputs on consecutive cycles 3-5 with lane j = base+(j^c) for each respective c.
REQ-032 Push full word set, assert rst=0 one cycle later -> valid stays 0 through the expected output cycle; d_out=0.
REQ-033 Random push masks and controls for 10k cycles against a delay-line reference model (i -> i^c, latency 3) -> zero mismatches, count of valid outputs equals count of pushes.

Source files
------------

// File: rtl/omega_unshuffle_network_ff_pkg.sv
// Shared compile-time helpers for the registered unshuffle (inverse omega) network.
package omega_unshuffle_network_ff_pkg;

    // Number of bits needed to represent value (log2(N-1) gives the stage count for N lanes).
    function automatic int log2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >>> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/omega_unshuffle_network_ff_switch.sv
// 2x2 registered switch: straight when sel=0, crossed when sel=1; lane bit 0 carries valid.
module unshuffle_switch_ff #(
    parameter int LANE_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANE_WIDTH-1:0] in_a,
    input  logic [LANE_WIDTH-1:0] in_b,
    input  logic                  sel,
    output logic [LANE_WIDTH-1:0] top,
    output logic [LANE_WIDTH-1:0] bottom
);

    // NOTE: the payload is cleared along with valid so d_out reads zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            top    <= '0;
            bottom <= '0;
        end else if (sel) begin
            top    <= in_b;
            bottom <= in_a;
        end else begin
            top    <= in_a;
            bottom <= in_b;
        end
    end

endmodule

// File: rtl/omega_unshuffle_network_ff.sv
// Registered inverse-shuffle network: a word pushed on lane i with control c exits on lane i^c.
module omega_unshuffle_network_ff
    import omega_unshuffle_network_ff_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int IN_PORTS         = 8,
    parameter int OUT_PORTS        = IN_PORTS,
    parameter int ADDR_WIDTH_PORTS = log2(OUT_PORTS - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [0:IN_PORTS-1]           push,
    input  logic [IN_PORTS*WIDTH-1:0]     d_in,
    input  logic [ADDR_WIDTH_PORTS-1:0]   control,
    output logic [0:OUT_PORTS-1]          valid,
    output logic [OUT_PORTS*WIDTH-1:0]    d_out
);

    localparam int N_STAGES   = ADDR_WIDTH_PORTS;
    localparam int HALF       = IN_PORTS / 2;
    localparam int LANE_WIDTH = WIDTH + 1;

    // lane[g] feeds stage g; lane[N_STAGES] is the registered network output.
    logic [LANE_WIDTH-1:0]       lane [N_STAGES+1][IN_PORTS];
    // ctrl_q[g] is the control word that travels with the data leaving stage g.
    logic [ADDR_WIDTH_PORTS-1:0] ctrl_q [N_STAGES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int g = 0; g < N_STAGES; g++) begin
                ctrl_q[g] <= '0;
            end
        end else begin
            ctrl_q[0] <= control;
            for (int g = 1; g < N_STAGES; g++) begin
                ctrl_q[g] <= ctrl_q[g-1];
            end
        end
    end

    for (genvar i = 0; i < IN_PORTS; i++) begin : g_in
        assign lane[0][i] = {d_in[(i+1)*WIDTH-1 -: WIDTH], push[i]};
    end

    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
        logic sel_bit;

        // Stage g consumes bit g of the word that entered alongside its data.
        if (g == 0) begin : g_first
            assign sel_bit = control[0];
        end else begin : g_later
            assign sel_bit = ctrl_q[g-1][g];
        end

        for (genvar k = 0; k < HALF; k++) begin : g_sw
            unshuffle_switch_ff #(
                .LANE_WIDTH (LANE_WIDTH)
            ) u_switch (
                .clk    (clk),
                .rst    (rst),
                .in_a   (lane[g][2*k]),
                .in_b   (lane[g][2*k+1]),
                .sel    (sel_bit),
                .top    (lane[g+1][k]),
                .bottom (lane[g+1][k+HALF])
            );
        end
    end

    for (genvar j = 0; j < OUT_PORTS; j++) begin : g_out
        assign valid[j]                      = lane[N_STAGES][j][0];
        assign d_out[(j+1)*WIDTH-1 -: WIDTH] = lane[N_STAGES][j][LANE_WIDTH-1:1];
    end

endmodule

// File: tb/tb_omega_unshuffle_network_ff.sv
// Directed and reference-model checks for omega_unshuffle_network_ff at default parameters.
module tb_omega_unshuffle_network_ff;

    localparam int W = 8;
    localparam int N = 8;
    localparam int A = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [0:N-1]     push = '0;
    logic [N*W-1:0]   d_in = '0;
    logic [A-1:0]     control = '0;
    logic [0:N-1]     valid;
    logic [N*W-1:0]   d_out;

    int total = 0;
    int bad   = 0;

    omega_unshuffle_network_ff #(
        .WIDTH            (W),
        .IN_PORTS         (N),
        .OUT_PORTS        (N),
        .ADDR_WIDTH_PORTS (A)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .d_in    (d_in),
        .control (control),
        .valid   (valid),
        .d_out   (d_out)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push    = '0;
        d_in    = '0;
        control = '0;
    endtask

    function automatic logic [N*W-1:0] pack_lanes(input logic [W-1:0] base);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[(i+1)*W-1 -: W] = base + W'(i);
        return v;
    endfunction

    // Lane j receives what was pushed on lane j^c.
    function automatic logic [N*W-1:0] expect_lanes(input logic [W-1:0] base, input logic [A-1:0] c);
        logic [N*W-1:0] v;
        for (int j = 0; j < N; j++) v[(j+1)*W-1 -: W] = base + W'(j ^ int'(c));
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0; push = '1; d_in = pack_lanes(8'h77); control = 3'b101;
        cycle(); cycle(); cycle();
        total++;
        if (valid !== '0) begin bad++; $display("FAIL reset_valid got=%h want=%h", valid, 8'h00); end
        total++;
        if (d_out !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", d_out); end
        rst = 1'b1; idle();
        for (int n = 0; n < 4; n++) begin
            cycle();
            total++;
            if (valid !== '0) begin bad++; $display("FAIL reset_inputs_discarded cyc=%0d got=%h want=00", n, valid); end
        end
    endtask

    task automatic test_full_permute();
        push = '1; d_in = pack_lanes(8'h10); control = 3'b101;
        cycle(); idle(); cycle(); cycle();
        total++;
        if (valid !== 8'hFF) begin bad++; $display("FAIL perm5_valid got=%h want=ff", valid); end
        total++;
        if (d_out !== expect_lanes(8'h10, 3'b101))
            begin bad++; $display("FAIL perm5_data got=%h want=%h", d_out, expect_lanes(8'h10, 3'b101)); end
        cycle();
        total++;
        if (valid !== '0) begin bad++; $display("FAIL perm5_after got=%h want=00", valid); end
    endtask

    task automatic test_single_lane();
        logic [0:N-1] ev;
        ev = '0; ev[3] = 1'b1;
        idle(); push[3] = 1'b1; d_in[4*W-1 -: W] = 8'hA5;
        cycle(); idle(); cycle(); cycle();
        total++;
        if (valid !== ev) begin bad++; $display("FAIL lane3_valid got=%h want=%h", valid, ev); end
        total++;
        if (d_out[4*W-1 -: W] !== 8'hA5) begin bad++; $display("FAIL lane3_data got=%h want=a5", d_out[4*W-1 -: W]); end
        cycle();
        total++;
        if (valid !== '0) begin bad++; $display("FAIL lane3_after got=%h want=00", valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] bases [3];
        logic [A-1:0] ctrls [3];
        bases = '{8'h20, 8'h40, 8'h60};
        ctrls = '{3'b001, 3'b110, 3'b111};
        for (int s = 0; s < 5; s++) begin
            if (s < 3) begin
                push = '1; d_in = pack_lanes(bases[s]); control = ctrls[s];
            end else begin
                idle();
            end
            cycle();
            if (s >= 2) begin
                total++;
                if (valid !== 8'hFF) begin bad++; $display("FAIL b2b_valid word=%0d got=%h want=ff", s-2, valid); end
                total++;
                if (d_out !== expect_lanes(bases[s-2], ctrls[s-2]))
                    begin bad++; $display("FAIL b2b_data word=%0d got=%h want=%h", s-2, d_out, expect_lanes(bases[s-2], ctrls[s-2])); end
            end
        end
        cycle();
        total++;
        if (valid !== '0) begin bad++; $display("FAIL b2b_after got=%h want=00", valid); end
    endtask

    task automatic test_reset_mid_flight();
        push = '1; d_in = pack_lanes(8'h30); control = 3'b011;
        cycle();
        idle(); rst = 1'b0;
        cycle();
        total++;
        if (valid !== '0) begin bad++; $display("FAIL midrst_during got=%h want=00", valid); end
        rst = 1'b1;
        cycle();
        total++;
        if (valid !== '0) begin bad++; $display("FAIL midrst_valid got=%h want=00", valid); end
        total++;
        if (d_out !== '0) begin bad++; $display("FAIL midrst_data got=%h want=0", d_out); end
        cycle();
        total++;
        if (valid !== '0) begin bad++; $display("FAIL midrst_after got=%h want=00", valid); end
    endtask

    task automatic test_random();
        logic [0:N-1]   hv [3];
        logic [N*W-1:0] hd [3];
        logic [0:N-1]   ev;
        logic [N*W-1:0] ed;
        int pushes;
        int outs;
        int c;
        int errs;
        idle();
        cycle(); cycle(); cycle();
        for (int k = 0; k < 3; k++) begin hv[k] = '0; hd[k] = '0; end
        pushes = 0; outs = 0; errs = 0;
        for (int n = 0; n < 10002; n++) begin
            if (n < 10000) begin
                push    = N'($urandom);
                d_in    = {$urandom, $urandom};
                control = A'($urandom_range(0, 7));
            end else begin
                idle();
            end
            ev = '0; ed = '0; c = int'(control);
            for (int i = 0; i < N; i++) begin
                ev[i ^ c] = push[i];
                ed[((i ^ c)+1)*W-1 -: W] = d_in[(i+1)*W-1 -: W];
            end
            hv[2] = hv[1]; hd[2] = hd[1];
            hv[1] = hv[0]; hd[1] = hd[0];
            hv[0] = ev;    hd[0] = ed;
            pushes += $countones(push);
            cycle();
            outs += $countones(valid);
            errs = 0;
            if (valid !== hv[2]) errs++;
            for (int j = 0; j < N; j++)
                if (hv[2][j] && d_out[(j+1)*W-1 -: W] !== hd[2][(j+1)*W-1 -: W]) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL random cyc=%0d valid got=%h want=%h data got=%h want=%h", n, valid, hv[2], d_out, hd[2]);
            end
        end
        total++;
        if (outs !== pushes) begin bad++; $display("FAIL random_count outputs=%0d pushes=%0d", outs, pushes); end
    endtask

    initial begin
        test_reset();
        test_full_permute();
        test_single_lane();
        test_back_to_back();
        test_reset_mid_flight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
